// File: rtl/wm8731_pkg.sv
// wm8731_pkg
// Shared definitions for the WM8731 control-port responder: I2C receive
// state encoding, the default device address, codec register map and the
// register address/data widths of the 16-bit control word.
package wm8731_pkg;

    localparam int WM8731_ADDR_W = 7;
    localparam int WM8731_DATA_W = 9;

    // Device address with CSB tied low.
    localparam logic [6:0] WM8731_DEV_ADDR = 7'h1A;

    localparam logic [6:0] WM8731_REG_LLINE  = 7'h00;
    localparam logic [6:0] WM8731_REG_RLINE  = 7'h01;
    localparam logic [6:0] WM8731_REG_LHP    = 7'h02;
    localparam logic [6:0] WM8731_REG_RHP    = 7'h03;
    localparam logic [6:0] WM8731_REG_APATH  = 7'h04;
    localparam logic [6:0] WM8731_REG_DPATH  = 7'h05;
    localparam logic [6:0] WM8731_REG_PWR    = 7'h06;
    localparam logic [6:0] WM8731_REG_DAIF   = 7'h07;
    localparam logic [6:0] WM8731_REG_SRATE  = 7'h08;
    localparam logic [6:0] WM8731_REG_ACTIVE = 7'h09;
    localparam logic [6:0] WM8731_REG_RESET  = 7'h0F;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_ACK_A  = 3'd2,
        ST_BYTE1  = 3'd3,
        ST_ACK_1  = 3'd4,
        ST_BYTE2  = 3'd5,
        ST_ACK_2  = 3'd6,
        ST_IGNORE = 3'd7
    } i2c_state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync
// Brings the asynchronous SCL/SDA pins into the system clock domain and
// derives bus events from a one-cycle history of the synchronised levels.
// Ports:
//   clk_sys, rst_n        system clock, async active-low reset
//   scl_i, sda_i          raw bus pins
//   sda_s                 synchronised SDA level
//   scl_rise, scl_fall    one-cycle SCL edge indications
//   start_det, stop_det   one-cycle START / STOP indications
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_hist_q, scl_hist_d;
    logic                   sda_hist_q, sda_hist_d;
    logic                   scl_s;

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
        scl_hist_d = scl_sync_q[SYNC_STAGES-1];
        sda_hist_d = sda_sync_q[SYNC_STAGES-1];
    end

    // Reset to the idle-bus level so leaving reset never fabricates an edge.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_hist_q <= scl_hist_d;
            sda_hist_q <= sda_hist_d;
        end
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_hist_q;
    assign scl_fall  = ~scl_s & scl_hist_q;
    // SCL must be high in both samples so an SDA change at an SCL edge is
    // not mistaken for a bus condition.
    assign start_det = scl_s & scl_hist_q & ~sda_s & sda_hist_q;
    assign stop_det  = scl_s & scl_hist_q & sda_s & ~sda_hist_q;

endmodule

// File: rtl/wm8731_i2c_slave.sv
// wm8731_i2c_slave
// Write-only I2C responder modelling the WM8731 control port. Receives
// START, device address, then two bytes forming {reg_addr[6:0], data[8:0]},
// acknowledges each, and emits a one-cycle write strobe.
// Optional build macro: WM8731_REGFILE_EN adds a 16x9 shadow register file
// (write to RESET clears it) readable through rf_rd_addr/rf_rd_data.
// Ports:
//   sys_clk50MHz, sys_rst_n  system clock (>= 8x SCL), async active-low reset
//   scl_i, sda_i             asynchronous bus pins
//   sda_oe                   1 pulls SDA low
//   reg_wr                   one-cycle write strobe
//   reg_addr, reg_data       last written word, held between strobes
//   busy                     addressed frame in progress (until STOP)
//   err_frame                pulse on STOP before the word completed
//   rf_rd_addr, rf_rd_data   shadow read port (zero when not built)
//
// state     | meaning
// ----------+-------------------------------------------------
// IDLE      | bus free or frame finished
// ADDR      | shifting in address + R/W bit
// ACK_A     | driving ACK for the address byte
// BYTE1     | shifting in {reg_addr, data[8]}
// ACK_1     | driving ACK for byte 1
// BYTE2     | shifting in data[7:0]
// ACK_2     | driving ACK for byte 2
// IGNORE    | not addressed, read request, or surplus bytes
module wm8731_i2c_slave
    import wm8731_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = WM8731_DEV_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                     sys_clk50MHz,
    input  logic                     sys_rst_n,
    input  logic                     scl_i,
    input  logic                     sda_i,
    output logic                     sda_oe,
    output logic                     reg_wr,
    output logic [WM8731_ADDR_W-1:0] reg_addr,
    output logic [WM8731_DATA_W-1:0] reg_data,
    output logic                     busy,
    output logic                     err_frame,
    input  logic [3:0]               rf_rd_addr,
    output logic [WM8731_DATA_W-1:0] rf_rd_data
);

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_bus_sync (
        .clk_sys   (sys_clk50MHz),
        .rst_n     (sys_rst_n),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    i2c_state_e               state_q, state_d;
    logic [2:0]               bit_cnt_q, bit_cnt_d;
    logic [7:0]               shift_q, shift_d;
    logic [7:0]               byte1_q, byte1_d;
    logic                     sda_oe_q, sda_oe_d;
    logic                     busy_q, busy_d;
    logic                     err_frame_q, err_frame_d;
    logic                     wr_pend_q, wr_pend_d;
    logic                     reg_wr_q, reg_wr_d;
    logic [WM8731_ADDR_W-1:0] reg_addr_q, reg_addr_d;
    logic [WM8731_DATA_W-1:0] reg_data_q, reg_data_d;
    logic [7:0]               rx_byte;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        byte1_d     = byte1_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        err_frame_d = 1'b0;
        wr_pend_d   = 1'b0;
        reg_wr_d    = wr_pend_q;
        reg_addr_d  = reg_addr_q;
        reg_data_d  = reg_data_q;
        rx_byte     = {shift_q[6:0], sda_s};

        // Byte 2 is still in the shifter the cycle after its last bit.
        if (wr_pend_q) begin
            reg_addr_d = byte1_q[7:1];
            reg_data_d = {byte1_q[0], shift_q};
        end

        if (start_det) begin
            state_d   = ST_ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else if (stop_det) begin
            state_d     = ST_IDLE;
            sda_oe_d    = 1'b0;
            busy_d      = 1'b0;
            err_frame_d = (state_q == ST_BYTE1) || (state_q == ST_ACK_1) ||
                          (state_q == ST_BYTE2);
        end else begin
            case (state_q)
                ST_ADDR, ST_BYTE1, ST_BYTE2: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (state_q == ST_ADDR) begin
                                if (rx_byte[7:1] == DEV_ADDR && !rx_byte[0]) begin
                                    state_d = ST_ACK_A;
                                    busy_d  = 1'b1;
                                end else begin
                                    state_d = ST_IGNORE;
                                end
                            end else if (state_q == ST_BYTE1) begin
                                byte1_d = rx_byte;
                                state_d = ST_ACK_1;
                            end else begin
                                wr_pend_d = 1'b1;
                                state_d   = ST_ACK_2;
                            end
                        end
                    end
                end
                // First SCL fall in an ACK state ends bit 8 and starts driving;
                // the next one ends the 9th clock and releases SDA.
                ST_ACK_A, ST_ACK_1, ST_ACK_2: begin
                    if (scl_fall) begin
                        sda_oe_d = !sda_oe_q;
                        if (sda_oe_q) begin
                            state_d = (state_q == ST_ACK_A) ? ST_BYTE1 :
                                      (state_q == ST_ACK_1) ? ST_BYTE2 : ST_IGNORE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk50MHz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            byte1_q     <= '0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            err_frame_q <= 1'b0;
            wr_pend_q   <= 1'b0;
            reg_wr_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            byte1_q     <= byte1_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            err_frame_q <= err_frame_d;
            wr_pend_q   <= wr_pend_d;
            reg_wr_q    <= reg_wr_d;
            reg_addr_q  <= reg_addr_d;
            reg_data_q  <= reg_data_d;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign busy      = busy_q;
    assign err_frame = err_frame_q;
    assign reg_wr    = reg_wr_q;
    assign reg_addr  = reg_addr_q;
    assign reg_data  = reg_data_q;

`ifdef WM8731_REGFILE_EN
    logic [WM8731_DATA_W-1:0] shadow_q [16];
    logic [WM8731_DATA_W-1:0] shadow_d [16];

    always_comb begin
        shadow_d = shadow_q;
        if (reg_wr_q) begin
            if (reg_addr_q == WM8731_REG_RESET) begin
                for (int i = 0; i < 16; i++) shadow_d[i] = '0;
            end else if (reg_addr_q[6:4] == 3'd0) begin
                shadow_d[reg_addr_q[3:0]] = reg_data_q;
            end
        end
    end

    always_ff @(posedge sys_clk50MHz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < 16; i++) shadow_q[i] <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end

    assign rf_rd_data = shadow_q[rf_rd_addr];
`else
    logic unused_rf_rd_addr;
    assign unused_rf_rd_addr = ^rf_rd_addr;
    assign rf_rd_data        = '0;
`endif

endmodule

// File: tb/tb_wm8731_i2c_slave.sv
module tb_wm8731_i2c_slave;

    localparam int         SYNC = 3;
    localparam logic [6:0] DEV  = 7'h1A;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_oe, reg_wr, busy, err_frame;
    logic [6:0] reg_addr;
    logic [8:0] reg_data, rf_rd_data;
    logic [3:0] rf_rd_addr = 4'd0;

    assign sda_line = sda_m & ~sda_oe;

    wm8731_i2c_slave #(.DEV_ADDR(DEV), .SYNC_STAGES(SYNC)) dut (
        .sys_clk50MHz (clk),
        .sys_rst_n    (rst_n),
        .scl_i        (scl),
        .sda_i        (sda_line),
        .sda_oe       (sda_oe),
        .reg_wr       (reg_wr),
        .reg_addr     (reg_addr),
        .reg_data     (reg_data),
        .busy         (busy),
        .err_frame    (err_frame),
        .rf_rd_addr   (rf_rd_addr),
        .rf_rd_data   (rf_rd_data)
    );

    always #10 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [6:0] exp_addr_q[$];
    logic [8:0] exp_data_q[$];
    logic [6:0] held_addr = 7'd0;
    logic [8:0] held_data = 9'd0;
    logic [8:0] shadow [16];
    int         exp_err = 0;
    int         seen_err = 0;
    bit         model_busy = 1'b0;
    int         q = 5;
    logic [7:0] fb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        held_addr  = 7'd0;
        held_data  = 9'd0;
        model_busy = 1'b0;
        exp_addr_q.delete();
        exp_data_q.delete();
        for (int i = 0; i < 16; i++) shadow[i] = 9'd0;
    endtask

    // Compare process
    logic [6:0] pop_a;
    logic [8:0] pop_d;
    logic [8:0] rf_exp;
    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset sda_oe", 32'(sda_oe), 32'd0);
            check("reset reg_wr", 32'(reg_wr), 32'd0);
            check("reset reg_addr", 32'(reg_addr), 32'd0);
            check("reset reg_data", 32'(reg_data), 32'd0);
            check("reset busy", 32'(busy), 32'd0);
            check("reset err_frame", 32'(err_frame), 32'd0);
            check("reset rf_rd_data", 32'(rf_rd_data), 32'd0);
        end else begin
`ifdef WM8731_REGFILE_EN
            rf_exp = shadow[rf_rd_addr];
`else
            rf_exp = 9'd0;
`endif
            check("rf_rd_data", 32'(rf_rd_data), 32'(rf_exp));
            if (reg_wr) begin
                if (exp_addr_q.size() == 0) begin
                    check("unexpected reg_wr", 32'd1, 32'd0);
                end else begin
                    pop_a = exp_addr_q.pop_front();
                    pop_d = exp_data_q.pop_front();
                    check("strobe reg_addr", 32'(reg_addr), 32'(pop_a));
                    check("strobe reg_data", 32'(reg_data), 32'(pop_d));
                    held_addr = pop_a;
                    held_data = pop_d;
                    if (pop_a == 7'h0F) begin
                        for (int i = 0; i < 16; i++) shadow[i] = 9'd0;
                    end else if (pop_a < 7'd16) begin
                        shadow[pop_a[3:0]] = pop_d;
                    end
                end
            end else begin
                check("held reg_addr", 32'(reg_addr), 32'(held_addr));
                check("held reg_data", 32'(reg_data), 32'(held_data));
            end
            if (err_frame) seen_err++;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1 rf_rd_addr = 4'($urandom_range(0, 15));
        end
    end

    initial begin
        #(20 * 90000);
        $display("FAIL watchdog: simulation exceeded cycle budget, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_start();
        sda_m = 1'b1; cyc(q);
        scl   = 1'b1; cyc(q);
        sda_m = 1'b0; cyc(q);
        scl   = 1'b0; cyc(q);
    endtask

    task automatic send_stop();
        sda_m = 1'b0; cyc(q);
        scl   = 1'b1; cyc(q);
        sda_m = 1'b1; cyc(q);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b; cyc(q);
        scl = 1'b1; cyc(q);
        check("sda_oe during master bit", 32'(sda_oe), 32'd0);
        cyc(q);
        scl = 1'b0; cyc(q);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit exp_ack, input bit do_rst,
                             output bit aborted);
        aborted = 1'b0;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_m = 1'b1; cyc(q);
        scl = 1'b1; cyc(q);
        check("ack on 9th clock (0=ACK)", 32'(sda_line), 32'(!exp_ack));
        check("busy", 32'(busy), 32'(model_busy));
        if (do_rst) begin
            rst_n = 1'b0;
            #1;
            check("sda_oe released by async reset", 32'(sda_oe), 32'd0);
            check("busy cleared by async reset", 32'(busy), 32'd0);
            model_reset();
            cyc(3);
            rst_n = 1'b1;
            cyc(3);
            aborted = 1'b1;
            return;
        end
        cyc(q);
        scl = 1'b0; cyc(q);
    endtask

    // Sends fb[] as complete bytes. trunc_bits > 0 appends that many bits of
    // tbyte and leaves the bus for a repeated START; otherwise ends with STOP.
    task automatic run_frame(input int trunc_bits, input logic [7:0] tbyte, input bit rst_at_ack1);
        bit         match;
        bit         aborted;
        bit         ea;
        logic [7:0] b0, b1, b2;
        b0 = fb[0];
        match = (b0[7:1] == DEV) && !b0[0];
        send_start();
        if (match) model_busy = 1'b1;
        if (match && fb.size() >= 3 && !rst_at_ack1) begin
            b1 = fb[1];
            b2 = fb[2];
            exp_addr_q.push_back(b1[7:1]);
            exp_data_q.push_back({b1[0], b2});
        end
        aborted = 1'b0;
        for (int k = 0; k < fb.size(); k++) begin
            ea = match && (k <= 2);
            send_byte(fb[k], ea, rst_at_ack1 && (k == 1), aborted);
            if (aborted) return;
        end
        if (trunc_bits > 0) begin
            for (int i = 7; i > 7 - trunc_bits; i--) send_bit(tbyte[i]);
            return;
        end
        send_stop();
        if (match && fb.size() < 3) exp_err++;
        model_busy = 1'b0;
        cyc(2);
        check("busy after STOP", 32'(busy), 32'd0);
    endtask

    task automatic set_fb(input int n, input logic [7:0] a0, input logic [7:0] a1,
                          input logic [7:0] a2, input logic [7:0] a3);
        fb.delete();
        fb.push_back(a0);
        if (n > 1) fb.push_back(a1);
        if (n > 2) fb.push_back(a2);
        if (n > 3) fb.push_back(a3);
    endtask

    logic [7:0] ra;
    int         rn, rt;

    initial begin
        model_reset();
        cyc(5);
        rst_n = 1'b1;
        cyc(5);

        q = 5;
        set_fb(3, 8'h34, 8'h08, 8'h12, 8'h00);
        run_frame(0, 8'h00, 1'b0);
        check("frame1 reg_addr literal", 32'(reg_addr), 32'h04);
        check("frame1 reg_data literal", 32'(reg_data), 32'h012);

        set_fb(3, 8'h36, 8'h08, 8'h12, 8'h00);
        run_frame(0, 8'h00, 1'b0);

        set_fb(2, 8'h35, 8'h00, 8'h00, 8'h00);
        run_frame(0, 8'h00, 1'b0);

        set_fb(2, 8'h34, 8'h08, 8'h00, 8'h00);
        run_frame(0, 8'h00, 1'b0);
        check("err_frame pulses after truncated frame", 32'(seen_err), 32'd1);

        set_fb(2, 8'h34, 8'h08, 8'h00, 8'h00);
        run_frame(4, 8'h55, 1'b0);
        set_fb(3, 8'h34, 8'h0D, 8'h9F, 8'h00);
        run_frame(0, 8'h00, 1'b0);
        check("restart reg_addr literal", 32'(reg_addr), 32'h06);
        check("restart reg_data literal", 32'(reg_data), 32'h19F);

        set_fb(3, 8'h34, 8'h08, 8'h12, 8'h00);
        run_frame(0, 8'h00, 1'b1);
        set_fb(3, 8'h34, 8'h10, 8'h01, 8'h00);
        run_frame(0, 8'h00, 1'b0);
        check("post-reset reg_addr literal", 32'(reg_addr), 32'h08);
        check("post-reset reg_data literal", 32'(reg_data), 32'h001);

        q = 31;
        set_fb(4, 8'h34, 8'h0E, 8'h02, 8'hAA);
        run_frame(0, 8'h00, 1'b0);
        check("400k reg_addr literal", 32'(reg_addr), 32'h07);
        check("400k reg_data literal", 32'(reg_data), 32'h002);

        for (int f = 0; f < 15; f++) begin
            q = $urandom_range(5, 9);
            case ($urandom_range(0, 3))
                0:       ra = 8'h34;
                1:       ra = 8'h35;
                2:       ra = 8'h36;
                default: ra = 8'($urandom_range(0, 255));
            endcase
            fb.delete();
            fb.push_back(ra);
            rn = $urandom_range(0, 4);
            for (int j = 0; j < rn; j++) fb.push_back(8'($urandom_range(0, 255)));
            rt = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            run_frame(rt, 8'($urandom_range(0, 255)), 1'b0);
        end

        q = 5;
        set_fb(3, 8'h34, 8'h1E, 8'h00, 8'h00);
        run_frame(0, 8'h00, 1'b0);
        check("reset-reg reg_addr literal", 32'(reg_addr), 32'h0F);
        check("reset-reg reg_data literal", 32'(reg_data), 32'h000);

        cyc(20);
        check("pending expected writes", 32'(exp_addr_q.size()), 32'd0);
        check("err_frame pulse count", 32'(seen_err), 32'(exp_err));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
